aes_key_expansion: RTL and testbench
====================================

// Module: aes_key_expansion
// PURPOSE
//  AES-128 key schedule. Expands the 128-bit cipher key into 11 round keys (round 0..10),
//  one round key per clock, and holds them in an internal register file.
//  Sits beside the AES round datapath and supplies the AddRoundKey stage, which reads
//  round keys through a registered read port indexed by round number.
// PARAMETERS
//  NUM_ROUNDS  10  last round index; the array holds NUM_ROUNDS+1 keys (only 10 supported)
//  SEL_W       4   width of the round-select index
// PORTS
//  i_clock        in   1      single clock; all state updates on the rising edge
//  i_reset_n      in   1      asynchronous, active-low reset
//  i_start        in   1      one-cycle pulse: capture i_key and begin expansion
//  i_key          in   128    cipher key, bit order [0:127], byte 0 = bits [0:7]
//  i_round_sel    in   SEL_W  round key index to read (0..10)
//  o_round_key    out  128    registered round key for i_round_sel, bit order [0:127]
//  o_busy         out  1      high while expansion is in progress
//  o_ready        out  1      high when all 11 round keys are valid
// BEHAVIOUR
//  Reset (async assert, sync release): FSM=IDLE, o_busy=0, o_ready=0, o_round_key=0,
//   round counter=0, rcon=8'h01, all key array entries=0.
//  Word layout: round key r = {w[4r], w[4r+1], w[4r+2], w[4r+3]}; w[4r] = bits [0:31].
//  FSM states:
//   IDLE:   on i_start -> write i_key to entry 0, rnd<=1, rcon<=01, go EXPAND.
//   EXPAND: each cycle compute round key rnd from entry rnd-1:
//           t = SubWord(RotWord(w3_prev)) ^ {rcon,24'h0}; w0=w0p^t; w1=w1p^w0;
//           w2=w2p^w1; w3=w3p^w2 (all chained combinationally, one cycle).
//           Write entry rnd; rnd<=rnd+1; rcon<=xtime(rcon) (0x80 -> 0x1B).
//           After writing entry NUM_ROUNDS -> go READY.
//   READY:  o_ready=1; on i_start restart exactly as from IDLE (o_ready drops next cycle).
//  Latency: i_start at cycle 0 -> entry 0 written end of cycle 0; entry r end of cycle r;
//   o_ready high from cycle 11; o_busy high cycles 1..10.
//  Rcon sequence: 01,02,04,08,10,20,40,80,1B,36.
//  i_start while EXPAND: ignored; expansion continues with the original key.
//  Read port: o_round_key <= key[i_round_sel] every cycle (1-cycle latency), regardless of FSM state;
//   i_round_sel > NUM_ROUNDS -> o_round_key <= 0. Entries not yet rewritten in the
//   current expansion hold prior contents; consumers must wait for o_ready.
//  Read and write of the same entry in one cycle: read returns the pre-write value.
//  Reset mid-expansion: everything returns to reset values immediately; no partial keys kept.
// STRUCTURE
//  Shared package (aes_pkg): AES_NR=10, Rcon table, xtime function, S-box table/function,
//   and the byte-lane helper for [0:127] word/byte slicing; shared with the SubBytes stage.
//  One sub-module: aes_sub_word (32-bit in -> 32-bit out, 4 parallel S-box lookups, combinational).
//  Key array: 11 x 128 flops; FSM + 4-bit round counter + 8-bit rcon register in this module.
// TESTING
//  1 FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, pulse i_start -> o_ready at cycle 11;
//    round 1 = a0fafe1788542cb123a339392a6c7605, round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
//  2 All-zero key -> round 1 = 62636363626363636263636362636363,
//    round 10 = b4ef5bcb3e92e21123e951cf6f8f188e; round 0 reads back all zero.
//  3 Sweep i_round_sel 0..15 after o_ready -> keys appear one cycle after select; 11..15 read 0.
//  4 Pulse i_start again at cycle 5 of expansion with a different key -> ignored; results equal
//    case 1. Then i_start from READY with zero key -> o_ready low next cycle, case 2 results.
//  5 Assert i_reset_n=0 at cycle 6 of expansion -> o_busy, o_ready, o_round_key go 0
//    immediately; all entries read 0 after release.
//  6 Check o_busy high exactly cycles 1..10 and rcon sequence via round keys 1..10 vs golden model.

Source files
------------

// File: rtl/aes_key_expansion_pkg.sv
// Shared AES definitions: round count, key-schedule FSM states, S-box,
// GF(2^8) doubling and [0:127] word/byte lane helpers.
package aes_key_expansion_pkg;

  localparam int AES_NR = 10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_READY  = 2'd2
  } ks_state_e;

  // Byte n of the S-box lives at bits [8n : 8n+7]
  localparam logic [0:2047] SBOX_FLAT = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b);
    sbox = SBOX_FLAT[{b, 3'b000} +: 8];
  endfunction

  function automatic logic [0:31] get_word(input logic [0:127] blk, input logic [1:0] idx);
    get_word = blk[{idx, 5'b00000} +: 32];
  endfunction

  function automatic logic [0:7] get_byte(input logic [0:31] w, input logic [1:0] idx);
    get_byte = w[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/aes_key_expansion_if.sv
// Control/data bundle between the AES round controller and the key schedule.
interface aes_key_expansion_if #(parameter int SEL_W = 4);
  logic             i_start;
  logic [0:127]     i_key;
  logic [SEL_W-1:0] i_round_sel;
  logic [0:127]     o_round_key;
  logic             o_busy;
  logic             o_ready;

  modport master (output i_start, i_key, i_round_sel, input o_round_key, o_busy, o_ready);
  modport slave  (input i_start, i_key, i_round_sel, output o_round_key, o_busy, o_ready);
endinterface

// File: rtl/aes_key_expansion_sub_word.sv
// SubWord: four parallel S-box substitutions on a 32-bit word, purely combinational.
module aes_sub_word
  import aes_key_expansion_pkg::*;
(
  input  logic [0:31] word_in,
  output logic [0:31] word_out
);

  // Substitute each byte lane independently
  always_comb begin
    word_out = 32'h0000_0000;
    for (int i = 0; i < 4; i++) begin
      word_out[i*8 +: 8] = sbox(get_byte(word_in, i[1:0]));
    end
  end

endmodule

// File: rtl/aes_key_expansion.sv
// AES-128 key schedule: produces one round key per clock into an 11-entry
// register file and serves them through a registered read port.
module aes_key_expansion
  import aes_key_expansion_pkg::*;
#(
  parameter int NUM_ROUNDS = AES_NR,
  parameter int SEL_W      = 4
) (
  input  logic           i_clock,
  input  logic           i_reset_n,
  aes_key_expansion_if.slave bus
);

  localparam logic [SEL_W-1:0] LAST_RND = SEL_W'(NUM_ROUNDS);
  localparam logic [SEL_W-1:0] RND_ONE  = SEL_W'(1'b1);

  ks_state_e        state_r, next_state_s;
  logic [0:127]     key_r [0:NUM_ROUNDS];
  logic [SEL_W-1:0] rnd_r, rnd_next_s;
  logic [7:0]       rcon_r, rcon_next_s;
  logic [0:127]     round_key_r;
  logic             busy_r, ready_r, busy_next_s, ready_next_s;
  logic             wr_en_s;
  logic [SEL_W-1:0] wr_idx_s, prev_idx_s;
  logic [0:127]     wr_data_s, prev_s, expanded_s;
  logic [0:31]      w3p_s, rot_s, sub_s, w0_s, w1_s, w2_s, w3_s;

  // Previous round index, clamped so IDLE/READY never index outside the array
  always_comb begin
    if ((rnd_r != {SEL_W{1'b0}}) && (rnd_r <= LAST_RND)) begin
      prev_idx_s = rnd_r - RND_ONE;
    end else begin
      prev_idx_s = {SEL_W{1'b0}};
    end
  end

  assign prev_s = key_r[prev_idx_s];
  assign w3p_s  = get_word(prev_s, 2'd3);
  assign rot_s  = {w3p_s[8:31], w3p_s[0:7]};

  aes_sub_word u_sub_word (
    .word_in  (rot_s),
    .word_out (sub_s)
  );

  assign w0_s       = get_word(prev_s, 2'd0) ^ sub_s ^ {rcon_r, 24'h00_0000};
  assign w1_s       = get_word(prev_s, 2'd1) ^ w0_s;
  assign w2_s       = get_word(prev_s, 2'd2) ^ w1_s;
  assign w3_s       = w3p_s ^ w2_s;
  assign expanded_s = {w0_s, w1_s, w2_s, w3_s};

  // FSM state register
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next-state logic; i_start is ignored while expanding
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE, ST_READY: begin
        if (bus.i_start) next_state_s = ST_EXPAND;
        else             next_state_s = state_r;
      end
      ST_EXPAND: begin
        if (rnd_r == LAST_RND) next_state_s = ST_READY;
        else                   next_state_s = ST_EXPAND;
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // FSM outputs: key-array write port, counter/rcon updates, next status flags
  always_comb begin
    wr_en_s      = 1'b0;
    wr_idx_s     = {SEL_W{1'b0}};
    wr_data_s    = 128'h0;
    rnd_next_s   = rnd_r;
    rcon_next_s  = rcon_r;
    busy_next_s  = (next_state_s == ST_EXPAND);
    ready_next_s = (next_state_s == ST_READY);
    case (state_r)
      ST_IDLE, ST_READY: begin
        if (bus.i_start) begin
          wr_en_s     = 1'b1;
          wr_data_s   = bus.i_key;
          rnd_next_s  = RND_ONE;
          rcon_next_s = 8'h01;
        end else begin
          wr_en_s = 1'b0;
        end
      end
      ST_EXPAND: begin
        wr_en_s     = 1'b1;
        wr_idx_s    = rnd_r;
        wr_data_s   = expanded_s;
        rnd_next_s  = rnd_r + RND_ONE;
        rcon_next_s = xtime(rcon_r);
      end
      default: wr_en_s = 1'b0;
    endcase
  end

  // Round counter, rcon and status flags
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rnd_r   <= {SEL_W{1'b0}};
      rcon_r  <= 8'h01;
      busy_r  <= 1'b0;
      ready_r <= 1'b0;
    end else begin
      rnd_r   <= rnd_next_s;
      rcon_r  <= rcon_next_s;
      busy_r  <= busy_next_s;
      ready_r <= ready_next_s;
    end
  end

  // Round-key register file
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i <= NUM_ROUNDS; i++) key_r[i] <= 128'h0;
    end else if (wr_en_s) begin
      key_r[wr_idx_s] <= wr_data_s;
    end
  end

  // Registered read port; same-cycle writes are not bypassed
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      round_key_r <= 128'h0;
    end else if (bus.i_round_sel <= LAST_RND) begin
      round_key_r <= key_r[bus.i_round_sel];
    end else begin
      round_key_r <= 128'h0;
    end
  end

  assign bus.o_round_key = round_key_r;
  assign bus.o_busy      = busy_r;
  assign bus.o_ready     = ready_r;

endmodule

// File: tb/tb_aes_key_expansion.sv
// Directed bench for the AES-128 key schedule: vector table plus hand-written
// restart, ignored-start and mid-expansion reset sequences.
module tb_aes_key_expansion;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  aes_key_expansion_if #(.SEL_W(4)) bus ();

  aes_key_expansion #(.NUM_ROUNDS(10), .SEL_W(4)) dut (
    .i_clock   (clk),
    .i_reset_n (rst_n),
    .bus       (bus)
  );

  localparam logic [127:0] KEY_FIPS = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY_ZERO = 128'h0;

  typedef struct {
    logic [127:0] key;
    logic [3:0]   sel;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs[$];
  int n_checks = 0;
  int n_fail   = 0;
  logic [127:0] loaded;
  logic [127:0] rd;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic start_exp(input logic [127:0] k);
    bus.i_key   = k;
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!bus.o_ready && n < 20) begin
      tick();
      n++;
    end
    check("ready_timeout", {127'h0, bus.o_ready}, 128'h1);
  endtask

  task automatic read_key(input logic [3:0] sel, output logic [127:0] k);
    bus.i_round_sel = sel;
    tick();
    k = bus.o_round_key;
  endtask

  initial begin
    bus.i_start     = 1'b0;
    bus.i_key       = 128'h0;
    bus.i_round_sel = 4'd0;

    vecs.push_back('{KEY_FIPS, 4'd0,  128'h2b7e151628aed2a6abf7158809cf4f3c});
    vecs.push_back('{KEY_FIPS, 4'd1,  128'ha0fafe1788542cb123a339392a6c7605});
    vecs.push_back('{KEY_FIPS, 4'd2,  128'hf2c295f27a96b9435935807a7359f67f});
    vecs.push_back('{KEY_FIPS, 4'd3,  128'h3d80477d4716fe3e1e237e446d7a883b});
    vecs.push_back('{KEY_FIPS, 4'd4,  128'hef44a541a8525b7fb671253bdb0bad00});
    vecs.push_back('{KEY_FIPS, 4'd5,  128'hd4d1c6f87c839d87caf2b8bc11f915bc});
    vecs.push_back('{KEY_FIPS, 4'd6,  128'h6d88a37a110b3efddbf98641ca0093fd});
    vecs.push_back('{KEY_FIPS, 4'd7,  128'h4e54f70e5f5fc9f384a64fb24ea6dc4f});
    vecs.push_back('{KEY_FIPS, 4'd8,  128'head27321b58dbad2312bf5607f8d292f});
    vecs.push_back('{KEY_FIPS, 4'd9,  128'hac7766f319fadc2128d12941575c006e});
    vecs.push_back('{KEY_FIPS, 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6});
    for (int s = 11; s < 16; s++) vecs.push_back('{KEY_FIPS, 4'(s), 128'h0});
    vecs.push_back('{KEY_ZERO, 4'd0,  128'h0});
    vecs.push_back('{KEY_ZERO, 4'd1,  128'h62636363626363636263636362636363});
    vecs.push_back('{KEY_ZERO, 4'd2,  128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa});
    vecs.push_back('{KEY_ZERO, 4'd10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e});
    vecs.push_back('{KEY_ZERO, 4'd12, 128'h0});

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy",  {127'h0, bus.o_busy},  128'h0);
    check("rst_ready", {127'h0, bus.o_ready}, 128'h0);
    check("rst_key",   bus.o_round_key,       128'h0);
    rst_n = 1'b1;
    tick();

    // Latency / busy window with the FIPS-197 key
    bus.i_key   = KEY_FIPS;
    bus.i_start = 1'b1;
    check("busy_c0", {127'h0, bus.o_busy}, 128'h0);
    tick();
    bus.i_start = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      check($sformatf("busy_c%0d", c),  {127'h0, bus.o_busy},  {127'h0, (c <= 10)});
      check($sformatf("ready_c%0d", c), {127'h0, bus.o_ready}, {127'h0, (c == 11)});
      if (c < 11) tick();
    end
    loaded = KEY_FIPS;

    // Vector table: round keys and out-of-range selects
    foreach (vecs[i]) begin
      if (vecs[i].key != loaded) begin
        start_exp(vecs[i].key);
        wait_ready();
        loaded = vecs[i].key;
      end
      read_key(vecs[i].sel, rd);
      check($sformatf("vec%0d_sel%0d", i, vecs[i].sel), rd, vecs[i].exp);
    end

    // Read latency: a new select does not show before the next edge
    read_key(4'd1, rd);
    bus.i_round_sel = 4'd2;
    #2;
    check("read_latency_hold", bus.o_round_key, 128'h62636363626363636263636362636363);

    // Start pulse during expansion is ignored
    bus.i_key   = KEY_FIPS;
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    repeat (4) tick();
    bus.i_key   = KEY_ZERO;
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    check("ignored_start_busy", {127'h0, bus.o_busy}, 128'h1);
    repeat (5) tick();
    check("ignored_start_ready_c11", {127'h0, bus.o_ready}, 128'h1);
    read_key(4'd1, rd);
    check("ignored_start_r1", rd, 128'ha0fafe1788542cb123a339392a6c7605);
    read_key(4'd10, rd);
    check("ignored_start_r10", rd, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // Restart from READY with the zero key
    start_exp(KEY_ZERO);
    check("restart_ready_drop", {127'h0, bus.o_ready}, 128'h0);
    wait_ready();
    read_key(4'd1, rd);
    check("restart_r1", rd, 128'h62636363626363636263636362636363);
    read_key(4'd10, rd);
    check("restart_r10", rd, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

    // Asynchronous reset in the middle of an expansion
    bus.i_round_sel = 4'd0;
    start_exp(KEY_FIPS);
    repeat (5) tick();
    check("pre_rst_busy", {127'h0, bus.o_busy}, 128'h1);
    check("pre_rst_key",  bus.o_round_key,      KEY_FIPS);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy",  {127'h0, bus.o_busy},  128'h0);
    check("mid_rst_ready", {127'h0, bus.o_ready}, 128'h0);
    check("mid_rst_key",   bus.o_round_key,       128'h0);
    tick();
    rst_n = 1'b1;
    tick();
    for (int r = 0; r <= 10; r++) begin
      read_key(4'(r), rd);
      check($sformatf("post_rst_entry%0d", r), rd, 128'h0);
    end
    check("post_rst_ready", {127'h0, bus.o_ready}, 128'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
